// File: rtl/vm_vend_sched.sv
// Vending machine sequencer: coin credit, round-robin slot grant, motor drive, change payout.
// Optional VM_MULTIVEND_EN: keep leftover credit in IDLE after a vend instead of paying change.
module vm_vend_sched #(
  parameter int unsigned N_SLOT       = 4,
  parameter int unsigned PRICE        = 4,
  parameter int unsigned CREDIT_MAX   = 8,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned DISP_TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic [1:0]          Coin,
  input  logic [N_SLOT-1:0]   Select,
  input  logic [N_SLOT-1:0]   Empty,
  input  logic                Refund,
  input  logic                Disp_done,
  input  logic                Pay_ack,
  output logic [N_SLOT-1:0]   Drink,
  output logic                Pay100,
  output logic                Pay50,
  output logic                Reject,
  output logic                Fault,
  output logic [CREDIT_W-1:0] Credit,
  output logic                Busy
);

  localparam int unsigned PtrW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int unsigned TmrW = $clog2(DISP_TIMEOUT + 1);
  localparam int unsigned CW1  = CREDIT_W + 1;

  localparam logic [CW1-1:0]  PriceX  = CW1'(PRICE);
  localparam logic [CW1-1:0]  MaxX    = CW1'(CREDIT_MAX);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(DISP_TIMEOUT - 1);
  localparam logic [PtrW-1:0] PtrRst  = PtrW'(N_SLOT - 1);

  typedef enum logic [1:0] {StIdle, StDispense, StPay, StPayGap} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [N_SLOT-1:0]   drink_q, drink_d;
  logic                pay100_q, pay100_d;
  logic                pay50_q, pay50_d;
  logic                reject_q, reject_d;
  logic                fault_q, fault_d;
  logic                busy_q, busy_d;

  logic [N_SLOT-1:0]   eligible;
  logic                grant_ok;
  logic [PtrW-1:0]     grant_idx;
  logic [PtrW-1:0]     cand;
  logic [CW1-1:0]      credit_x;
  logic [CW1-1:0]      coin_sum;

  // Search starts one past the last granted slot so every slot gets its turn.
  always_comb begin
    eligible  = Select & ~Empty;
    grant_ok  = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int unsigned i = 1; i <= N_SLOT; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_SLOT);
      if (!grant_ok && eligible[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    timer_d  = '0;
    reject_d = 1'b0;
    fault_d  = 1'b0;
    credit_x = {1'b0, credit_q};
    coin_sum = '0;

    unique case (state_q)
      StIdle: begin
        if (Refund && credit_q != '0) begin
          state_d = StPay;
        end else if (grant_ok && credit_x >= PriceX) begin
          state_d  = StDispense;
          ptr_d    = grant_idx;
          credit_x = credit_x - PriceX;
        end
        // Coin value equals its encoding for 01/10; overflow check sees the post-grant credit.
        if (Coin == 2'b11) begin
          reject_d = 1'b1;
        end else if (Coin != 2'b00) begin
          coin_sum = credit_x + CW1'(Coin);
          if (coin_sum > MaxX) reject_d = 1'b1;
          else                 credit_x = coin_sum;
        end
      end
      StDispense: begin
        timer_d = timer_q + 1'b1;
        if (Disp_done) begin
`ifdef VM_MULTIVEND_EN
          state_d = StIdle;
`else
          state_d = (credit_q != '0) ? StPay : StIdle;
`endif
        end else if (timer_q == TmrLast) begin
          fault_d  = 1'b1;
          credit_x = credit_x + PriceX;
          state_d  = StPay;
        end
      end
      StPay: begin
        if (Pay_ack) begin
          credit_x = (credit_x >= CW1'(2)) ? credit_x - CW1'(2) : credit_x - CW1'(1);
          state_d  = StPayGap;
        end
      end
      StPayGap: begin
        state_d = (credit_q != '0) ? StPay : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && Coin != 2'b00) reject_d = 1'b1;

    credit_d = credit_x[CREDIT_W-1:0];
    drink_d  = (state_d == StDispense) ? ({{(N_SLOT-1){1'b0}}, 1'b1} << ptr_d) : '0;
    pay100_d = (state_d == StPay) && (credit_x >= CW1'(2));
    pay50_d  = (state_d == StPay) && (credit_x == CW1'(1));
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      credit_q <= '0;
      ptr_q    <= PtrRst;
      timer_q  <= '0;
      drink_q  <= '0;
      pay100_q <= 1'b0;
      pay50_q  <= 1'b0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      drink_q  <= drink_d;
      pay100_q <= pay100_d;
      pay50_q  <= pay50_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
    end
  end

  assign Drink  = drink_q;
  assign Pay100 = pay100_q;
  assign Pay50  = pay50_q;
  assign Reject = reject_q;
  assign Fault  = fault_q;
  assign Credit = credit_q;
  assign Busy   = busy_q;

endmodule
